rv32i_branch_predictor: RTL

Parametrised dynamic branch predictor for the pipelined RV32I core: a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. The fetch stage looks it up combinationally to choose the next PC. The execute stage writes back each resolved branch or jump one entry per cycle. It replaces the core's fixed predict-not-taken behaviour, under which every taken branch flushes decode and execute.

---
 rtl/rv32i_branch_predictor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rv32i_branch_predictor.sv
// rv32i_branch_predictor: direct-mapped BTB with saturating direction counters; stats counters built only with BRANCH_PREDICTOR_STATS_EN.
// Latency: lookup is combinational (0 cycles); an update is visible to lookups from the cycle after its edge, no bypass.
// Backpressure: none; accepts one resolved branch per cycle, ena low freezes table, flush and statistics.
module rv32i_branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int COUNTER_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] lookup_pc_f,
  output logic        predict_taken_f,
  output logic [31:0] predict_target_f,
  input  logic        update_valid_e,
  input  logic [31:0] update_pc_e,
  input  logic        update_taken_e,
  input  logic [31:0] update_target_e,
  input  logic        update_is_jump_e,
  input  logic        update_mispredict_e,
  input  logic        flush_all,
  output logic [31:0] branches_resolved,
  output logic [31:0] mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [COUNTER_W-1:0] CTR_MAX = {COUNTER_W{1'b1}};
  localparam logic [COUNTER_W-1:0] CTR_WT  = COUNTER_W'(1 << (COUNTER_W - 1));
  localparam logic [COUNTER_W-1:0] CTR_WNT = CTR_WT - 1'b1;

  typedef struct packed {
    logic                 vld;
    logic [TAG_W-1:0]     tag;
    logic [31:0]          target;
    logic [COUNTER_W-1:0] ctr;
  } btb_entry_t;

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  btb_entry_t       lk_ent;
  logic             lk_hit;

  assign lk_idx = lookup_pc_f[IDX_W+1:2];
  assign lk_tag = lookup_pc_f[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = update_pc_e[IDX_W+1:2];
  assign up_tag = update_pc_e[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle write is not forwarded.
  assign lk_ent           = btb_q[lk_idx];
  assign lk_hit           = lk_ent.vld && (lk_ent.tag == lk_tag);
  assign predict_taken_f  = lk_hit && lk_ent.ctr[COUNTER_W-1];
  assign predict_target_f = predict_taken_f ? lk_ent.target : (lookup_pc_f + 32'd4);

  btb_entry_t up_old;
  btb_entry_t up_new;
  logic       up_hit;
  logic       up_wr;

  always_comb begin
    up_old = btb_q[up_idx];
    up_new = up_old;
    up_wr  = 1'b0;
    up_hit = up_old.vld && (up_old.tag == up_tag);
    if (up_hit) begin
      up_wr = 1'b1;
      if (update_is_jump_e) begin
        up_new.ctr    = CTR_MAX;
        up_new.target = update_target_e;
      end else if (update_taken_e) begin
        if (up_old.ctr != CTR_MAX) up_new.ctr = up_old.ctr + 1'b1;
        up_new.target = update_target_e;
      end else if (up_old.ctr != '0) begin
        up_new.ctr = up_old.ctr - 1'b1;
      end
    end else if (update_taken_e) begin
      // Allocation simply evicts whatever aliases to this index.
      up_wr         = 1'b1;
      up_new.vld    = 1'b1;
      up_new.tag    = up_tag;
      up_new.target = update_target_e;
      up_new.ctr    = update_is_jump_e ? CTR_MAX : CTR_WT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].vld    <= 1'b0;
        btb_q[i].tag    <= '0;
        btb_q[i].target <= '0;
        btb_q[i].ctr    <= CTR_WNT;
      end
    end else if (ena) begin
      if (flush_all) begin
        for (int i = 0; i < ENTRIES; i++) btb_q[i].vld <= 1'b0;
      end else if (update_valid_e && up_wr) begin
        btb_q[up_idx] <= up_new;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] resolved_q;
  logic [31:0] mispred_q;

  // Statistics count resolved instructions even when a flush drops the table write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resolved_q <= '0;
      mispred_q  <= '0;
    end else if (ena && update_valid_e) begin
      resolved_q <= resolved_q + 32'd1;
      if (update_mispredict_e) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign branches_resolved = resolved_q;
  assign mispredicts       = mispred_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_f, update_pc_e};
`else
  assign branches_resolved = 32'd0;
  assign mispredicts       = 32'd0;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_f, update_pc_e, update_mispredict_e};
`endif

endmodule
